// File: rtl/axi_lite_regfile_slave.sv
// AXI4-Lite register bank with a read-only ID register at the top index; AW/W accepted in either order.
// B valid 1 cycle after the completing handshake, R valid 1 cycle after AR; one write and one read in flight, readies drop while a response waits.
module axi_lite_regfile_slave #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8,
  parameter int RESP_WIDTH = 3,
  parameter int NUM_REGS   = 16,
  parameter logic [DATA_WIDTH-1:0] ID_VALUE = DATA_WIDTH'(32'hA5A5_0001)
) (
  input  logic                    s_axi_aclk,
  input  logic                    s_axi_areset,
  input  logic [ADDR_WIDTH-1:0]   s_axi_awaddr,
  input  logic                    s_axi_awvalid,
  output logic                    s_axi_awready,
  input  logic [DATA_WIDTH-1:0]   s_axi_wdata,
  input  logic [DATA_WIDTH/8:0]   s_axi_wstrb,
  input  logic                    s_axi_wvalid,
  output logic                    s_axi_wready,
  output logic [RESP_WIDTH-1:0]   s_axi_bresp,
  output logic                    s_axi_bvalid,
  input  logic                    s_axi_bready,
  input  logic [ADDR_WIDTH-1:0]   s_axi_araddr,
  input  logic                    s_axi_arvalid,
  output logic                    s_axi_arready,
  output logic [DATA_WIDTH-1:0]   s_axi_rdata,
  output logic [RESP_WIDTH-1:0]   s_axi_rresp,
  output logic                    s_axi_rvalid,
  input  logic                    s_axi_rready
);

  localparam int NBYTES = DATA_WIDTH / 8;
  localparam int STRB_W = NBYTES + 1;
  localparam int IDX_W  = ADDR_WIDTH - 2;
  localparam int SEL_W  = $clog2(NUM_REGS);

  localparam logic [RESP_WIDTH-1:0] RESP_OKAY   = '0;
  localparam logic [RESP_WIDTH-1:0] RESP_SLVERR = RESP_WIDTH'(2);

  typedef enum logic [1:0] {W_IDLE, W_WAIT_ADDR, W_WAIT_DATA, W_RESP} w_state_e;
  typedef enum logic {R_IDLE, R_DATA} r_state_e;

  typedef struct packed {
    logic [IDX_W-1:0]      idx;
    logic [DATA_WIDTH-1:0] data;
    logic [NBYTES-1:0]     strb;
  } wr_req_t;

  function automatic logic is_writable(input logic [IDX_W-1:0] idx);
    return int'(idx) < NUM_REGS - 1;
  endfunction

  function automatic logic is_id(input logic [IDX_W-1:0] idx);
    return int'(idx) == NUM_REGS - 1;
  endfunction

  function automatic logic [SEL_W-1:0] sel_of(input logic [IDX_W-1:0] idx);
    return idx[SEL_W-1:0];
  endfunction

  w_state_e                w_state_q, w_state_d;
  r_state_e                r_state_q, r_state_d;
  wr_req_t                 wr_q, wr_d;
  wr_req_t                 cm;
  logic                    commit;
  logic [DATA_WIDTH-1:0]   wr_word;
  logic [DATA_WIDTH-1:0]   regs_q [NUM_REGS];
  logic [DATA_WIDTH-1:0]   regs_d [NUM_REGS];
  logic                    awready_q, awready_d;
  logic                    wready_q, wready_d;
  logic                    bvalid_q, bvalid_d;
  logic [RESP_WIDTH-1:0]   bresp_q, bresp_d;
  logic                    arready_q, arready_d;
  logic                    rvalid_q, rvalid_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic [RESP_WIDTH-1:0]   rresp_q, rresp_d;

  logic                    aw_hs, w_hs, ar_hs;
  logic [IDX_W-1:0]        aw_idx, ar_idx;
  logic [NBYTES-1:0]       wstrb_lo;
  logic                    unused_bits;

  // Byte-offset bits and the extra strobe bit carry no meaning here.
  assign unused_bits = ^{s_axi_awaddr[1:0], s_axi_araddr[1:0], s_axi_wstrb[STRB_W-1]};

  assign aw_hs    = s_axi_awvalid && awready_q;
  assign w_hs     = s_axi_wvalid && wready_q;
  assign ar_hs    = s_axi_arvalid && arready_q;
  assign aw_idx   = s_axi_awaddr[ADDR_WIDTH-1:2];
  assign ar_idx   = s_axi_araddr[ADDR_WIDTH-1:2];
  assign wstrb_lo = s_axi_wstrb[NBYTES-1:0];

  always_comb begin
    w_state_d = w_state_q;
    wr_d      = wr_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    commit    = 1'b0;
    cm        = wr_q;
    wr_word   = '0;
    regs_d    = regs_q;

    case (w_state_q)
      W_IDLE: begin
        if (aw_hs && w_hs) begin
          commit  = 1'b1;
          cm.idx  = aw_idx;
          cm.data = s_axi_wdata;
          cm.strb = wstrb_lo;
        end else if (aw_hs) begin
          wr_d.idx  = aw_idx;
          w_state_d = W_WAIT_DATA;
        end else if (w_hs) begin
          wr_d.data = s_axi_wdata;
          wr_d.strb = wstrb_lo;
          w_state_d = W_WAIT_ADDR;
        end
      end
      W_WAIT_DATA: begin
        if (w_hs) begin
          commit  = 1'b1;
          cm.data = s_axi_wdata;
          cm.strb = wstrb_lo;
        end
      end
      W_WAIT_ADDR: begin
        if (aw_hs) begin
          commit = 1'b1;
          cm.idx = aw_idx;
        end
      end
      W_RESP: begin
        if (s_axi_bready) begin
          w_state_d = W_IDLE;
          bvalid_d  = 1'b0;
          bresp_d   = RESP_OKAY;
        end
      end
      default: w_state_d = W_IDLE;
    endcase

    if (commit) begin
      w_state_d = W_RESP;
      bvalid_d  = 1'b1;
      if (is_writable(cm.idx)) begin
        wr_word = regs_q[sel_of(cm.idx)];
        for (int b = 0; b < NBYTES; b++) begin
          if (cm.strb[b]) wr_word[b*8 +: 8] = cm.data[b*8 +: 8];
        end
        regs_d[sel_of(cm.idx)] = wr_word;
        bresp_d = RESP_OKAY;
      end else begin
        bresp_d = RESP_SLVERR;
      end
    end

    awready_d = (w_state_d == W_IDLE) || (w_state_d == W_WAIT_ADDR);
    wready_d  = (w_state_d == W_IDLE) || (w_state_d == W_WAIT_DATA);
  end

  // Reads sample regs_q, so a same-edge write commit is not yet visible.
  always_comb begin
    r_state_d = r_state_q;
    rvalid_d  = rvalid_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;

    case (r_state_q)
      R_IDLE: begin
        if (ar_hs) begin
          r_state_d = R_DATA;
          rvalid_d  = 1'b1;
          if (is_id(ar_idx)) begin
            rdata_d = ID_VALUE;
            rresp_d = RESP_OKAY;
          end else if (is_writable(ar_idx)) begin
            rdata_d = regs_q[sel_of(ar_idx)];
            rresp_d = RESP_OKAY;
          end else begin
            rdata_d = '0;
            rresp_d = RESP_SLVERR;
          end
        end
      end
      R_DATA: begin
        if (s_axi_rready) begin
          r_state_d = R_IDLE;
          rvalid_d  = 1'b0;
          rdata_d   = '0;
          rresp_d   = RESP_OKAY;
        end
      end
      default: r_state_d = R_IDLE;
    endcase

    arready_d = (r_state_d == R_IDLE);
  end

  always_ff @(posedge s_axi_aclk) begin
    if (s_axi_areset) begin
      w_state_q <= W_IDLE;
      r_state_q <= R_IDLE;
      wr_q      <= '0;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= '0;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= '0;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else begin
      w_state_q <= w_state_d;
      r_state_q <= r_state_d;
      wr_q      <= wr_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
      regs_q    <= regs_d;
    end
  end

  assign s_axi_awready = awready_q;
  assign s_axi_wready  = wready_q;
  assign s_axi_bvalid  = bvalid_q;
  assign s_axi_bresp   = bresp_q;
  assign s_axi_arready = arready_q;
  assign s_axi_rvalid  = rvalid_q;
  assign s_axi_rdata   = rdata_q;
  assign s_axi_rresp   = rresp_q;

endmodule

// File: tb/tb_axi_lite_regfile_slave.sv
// Directed bench for axi_lite_regfile_slave: hand-computed register values and responses.
module tb_axi_lite_regfile_slave;

  logic        clk = 1'b0;
  logic        areset;
  logic [7:0]  awaddr;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [4:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [2:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [7:0]  araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [2:0]  rresp;
  logic        rvalid;
  logic        rready;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  axi_lite_regfile_slave dut (
    .s_axi_aclk    (clk),
    .s_axi_areset  (areset),
    .s_axi_awaddr  (awaddr),
    .s_axi_awvalid (awvalid),
    .s_axi_awready (awready),
    .s_axi_wdata   (wdata),
    .s_axi_wstrb   (wstrb),
    .s_axi_wvalid  (wvalid),
    .s_axi_wready  (wready),
    .s_axi_bresp   (bresp),
    .s_axi_bvalid  (bvalid),
    .s_axi_bready  (bready),
    .s_axi_araddr  (araddr),
    .s_axi_arvalid (arvalid),
    .s_axi_arready (arready),
    .s_axi_rdata   (rdata),
    .s_axi_rresp   (rresp),
    .s_axi_rvalid  (rvalid),
    .s_axi_rready  (rready)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // mode 0: AW and W together, 1: W then AW three cycles later, 2: AW then W.
  task automatic do_write(input string tag, input logic [7:0] addr, input logic [31:0] data,
                          input logic [4:0] strb, input int mode, input int bwait,
                          input logic [2:0] exp_resp);
    logic [2:0] held;
    bready = (bwait == 0);
    awaddr = addr;
    wdata  = data;
    wstrb  = strb;
    case (mode)
      0: begin
        awvalid = 1'b1; wvalid = 1'b1;
        tick();
        awvalid = 1'b0; wvalid = 1'b0;
      end
      1: begin
        wvalid = 1'b1;
        tick();
        wvalid = 1'b0;
        for (int i = 0; i < 2; i++) begin
          chk({tag, "_wready_wait"}, {31'd0, wready}, 32'd0);
          tick();
        end
        chk({tag, "_rdy_wait_addr"}, {30'd0, awready, wready}, 32'd2);
        awvalid = 1'b1;
        tick();
        awvalid = 1'b0;
      end
      default: begin
        awvalid = 1'b1;
        tick();
        awvalid = 1'b0;
        chk({tag, "_rdy_wait_data"}, {30'd0, awready, wready}, 32'd1);
        wvalid = 1'b1;
        tick();
        wvalid = 1'b0;
      end
    endcase
    chk({tag, "_bvalid"}, {31'd0, bvalid}, 32'd1);
    chk({tag, "_bresp"}, {29'd0, bresp}, {29'd0, exp_resp});
    held = bresp;
    for (int i = 0; i < bwait; i++) begin
      tick();
      chk({tag, "_bhold"}, {28'd0, bvalid, bresp}, {28'd0, 1'b1, held});
      chk({tag, "_rdy_low"}, {30'd0, awready, wready}, 32'd0);
    end
    bready = 1'b1;
    tick();
    bready = 1'b0;
    chk({tag, "_bdone"}, {28'd0, bvalid, bresp}, 32'd0);
    chk({tag, "_rdy_back"}, {30'd0, awready, wready}, 32'd3);
  endtask

  task automatic do_read(input string tag, input logic [7:0] addr,
                         input logic [31:0] exp_data, input logic [2:0] exp_resp);
    araddr  = addr;
    arvalid = 1'b1;
    tick();
    arvalid = 1'b0;
    chk({tag, "_rvalid"}, {30'd0, rvalid, arready}, 32'd2);
    chk({tag, "_rdata"}, rdata, exp_data);
    chk({tag, "_rresp"}, {29'd0, rresp}, {29'd0, exp_resp});
    rready = 1'b1;
    tick();
    rready = 1'b0;
    chk({tag, "_rdone"}, {28'd0, rvalid, rresp}, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    areset = 1'b1;
    awaddr = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b0;
    araddr = '0; arvalid = 1'b0; rready = 1'b0;

    tick();
    tick();
    chk("rst_readies", {29'd0, awready, wready, arready}, 32'd0);
    chk("rst_valids", {30'd0, bvalid, rvalid}, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_resps", {26'd0, bresp, rresp}, 32'd0);
    areset = 1'b0;
    tick();
    chk("post_rst_readies", {29'd0, awready, wready, arready}, 32'd7);
    do_read("rd0", 8'h00, 32'h0000_0000, 3'd0);

    do_write("wr4", 8'h04, 32'h0000_0038, 5'h0F, 0, 0, 3'd0);
    do_read("rd4", 8'h04, 32'h0000_0038, 3'd0);

    do_write("wr8a", 8'h08, 32'hDEAD_BEEF, 5'b00101, 1, 0, 3'd0);
    do_read("rd8a", 8'h08, 32'h00AD_00EF, 3'd0);
    do_write("wr8b", 8'h08, 32'h1122_3344, 5'b01010, 2, 0, 3'd0);
    do_read("rd8b", 8'h0B, 32'h11AD_33EF, 3'd0);

    do_write("wr4_nostrb", 8'h04, 32'hFFFF_FFFF, 5'b00000, 0, 0, 3'd0);
    do_write("wr4_msbstrb", 8'h04, 32'hFFFF_FFFF, 5'b10000, 0, 0, 3'd0);
    do_read("rd4_keep", 8'h04, 32'h0000_0038, 3'd0);

    do_write("wr10_bp", 8'h10, 32'hCAFE_F00D, 5'h0F, 0, 5, 3'd0);
    do_write("wr14", 8'h14, 32'h0000_0005, 5'h0F, 0, 0, 3'd0);
    do_read("rd10", 8'h10, 32'hCAFE_F00D, 3'd0);
    do_read("rd14", 8'h14, 32'h0000_0005, 3'd0);

    do_write("wr_id", 8'h3C, 32'h1234_5678, 5'h0F, 0, 0, 3'd2);
    do_write("wr_oor", 8'h40, 32'h1234_5678, 5'h0F, 0, 0, 3'd2);
    do_read("rd_id", 8'h3C, 32'hA5A5_0001, 3'd0);
    do_read("rd_oor", 8'h40, 32'h0000_0000, 3'd2);

    // Read and write to the same register captured at one edge.
    araddr = 8'h0C; arvalid = 1'b1;
    awaddr = 8'h0C; awvalid = 1'b1; wdata = 32'h1234_5678; wstrb = 5'h0F; wvalid = 1'b1;
    tick();
    arvalid = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
    chk("coll_rdata_old", rdata, 32'h0000_0000);
    chk("coll_valids", {30'd0, bvalid, rvalid}, 32'd3);
    rready = 1'b1; bready = 1'b1;
    tick();
    rready = 1'b0; bready = 1'b0;
    chk("coll_done", {30'd0, bvalid, rvalid}, 32'd0);
    do_read("rdc_new", 8'h0C, 32'h1234_5678, 3'd0);

    // Reset with a read beat pending and write data latched.
    araddr = 8'h0C; arvalid = 1'b1;
    wdata = 32'hFFFF_FFFF; wstrb = 5'h0F; wvalid = 1'b1;
    tick();
    arvalid = 1'b0; wvalid = 1'b0;
    chk("mid_pending", {29'd0, rvalid, awready, wready}, 32'd6);
    areset = 1'b1;
    tick();
    chk("mid_rst_valid", {30'd0, bvalid, rvalid}, 32'd0);
    chk("mid_rst_rdata", rdata, 32'd0);
    areset = 1'b0;
    tick();
    chk("mid_rst_readies", {29'd0, awready, wready, arready}, 32'd7);
    do_read("rdc_clr", 8'h0C, 32'h0000_0000, 3'd0);
    do_write("wrc_post", 8'h0C, 32'h0000_00AA, 5'h0F, 2, 0, 3'd0);
    do_read("rdc_post", 8'h0C, 32'h0000_00AA, 3'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/axi_lite_regfile_slave.md
Name: axi_lite_regfile_slave

Overview:
- AXI4-Lite responder (subordinate) holding a bank of 32-bit memory-mapped registers.
- Instantiated behind each downstream master port of the bus interconnect (m1/m2), so one instance terminates each port.
- Accepts write address/data in either order, applies byte strobes, and returns one response per transaction.
- Serves single-beat reads in parallel with writes. The top register is a read-only ID register.

Parameters:
- DATA_WIDTH, 32, data bus width in bits; must be a multiple of 8.
- ADDR_WIDTH, 8, byte address width.
- RESP_WIDTH, 3, width of bresp/rresp; OKAY = 0, SLVERR = 2.
- NUM_REGS, 16, number of registers; word index = addr[ADDR_WIDTH-1:2].
- ID_VALUE, 32'hA5A5_0001, constant returned by register NUM_REGS-1.

Ports:
- s_axi_aclk  in  1  single clock, rising edge.
- s_axi_areset  in  1  synchronous reset, active-high.
- s_axi_awaddr  in  ADDR_WIDTH  write byte address.
- s_axi_awvalid  in  1  write address valid.
- s_axi_awready  out  1  write address ready.
- s_axi_wdata  in  DATA_WIDTH  write data.
- s_axi_wstrb  in  DATA_WIDTH/8+1  byte strobes; bit i enables byte i; MSB ignored.
- s_axi_wvalid  in  1  write data valid.
- s_axi_wready  out  1  write data ready.
- s_axi_bresp  out  RESP_WIDTH  write response.
- s_axi_bvalid  out  1  write response valid.
- s_axi_bready  in  1  write response accept.
- s_axi_araddr  in  ADDR_WIDTH  read byte address.
- s_axi_arvalid  in  1  read address valid.
- s_axi_arready  out  1  read address ready.
- s_axi_rdata  out  DATA_WIDTH  read data.
- s_axi_rresp  out  RESP_WIDTH  read response.
- s_axi_rvalid  out  1  read data valid.
- s_axi_rready  in  1  read data accept.

Behaviour:
- Reset (s_axi_areset=1 at a clock edge):
  - All registers clear to 0.
  - Both FSMs return to idle.
  - Every output is registered and 0 during reset: all ready/valid signals, bresp, rresp, rdata.
  - First edge with reset low: awready, wready and arready go 1.
- Reset mid-transaction: pending address/data is discarded and bvalid/rvalid drop at the next edge. No partial register update occurs.
- Write FSM, states W_IDLE, W_WAIT_ADDR, W_WAIT_DATA, W_RESP:
  - W_IDLE: awready=1, wready=1.
    - awvalid and wvalid both high: commit, go to W_RESP.
    - awvalid only: latch address, go to W_WAIT_DATA.
    - wvalid only: latch data and strobes, go to W_WAIT_ADDR.
  - W_WAIT_DATA: wready=1, awready=0. On wvalid: commit, go to W_RESP.
  - W_WAIT_ADDR: awready=1, wready=0. On awvalid: commit, go to W_RESP.
  - W_RESP: awready=wready=0, bvalid=1, bresp held stable. On bready: go to W_IDLE, with readies high the following cycle.
  - Commit: register updates at the commit edge; bvalid is 1 in the cycle after the completing handshake.
- Strobes:
  - Byte i is updated only if wstrb[i]=1.
  - wstrb[DATA_WIDTH/8] is ignored.
  - All strobes 0: no change, bresp=OKAY.
- Address decode:
  - addr[1:0] is ignored.
  - idx >= NUM_REGS: write dropped, bresp=SLVERR; read gives rdata=0, rresp=SLVERR.
  - idx = NUM_REGS-1: reads return ID_VALUE with OKAY; writes are dropped with SLVERR.
- Read FSM, states R_IDLE, R_DATA:
  - R_IDLE: arready=1. On arvalid, capture register contents into rdata/rresp and go to R_DATA; rvalid=1 the next cycle, so latency is 1.
  - R_DATA: arready=0; rvalid, rdata and rresp held stable until rready, then go to R_IDLE.
  - rresp=0 whenever rvalid=0.
- Simultaneous events:
  - A read captured at the same edge as a write commit to the same register returns the old (pre-write) value.
  - Read and write channels are fully independent; neither blocks the other.
- bresp=0 whenever bvalid=0.
- Exactly one B response per committed write and one R beat per accepted AR. No outstanding-transaction queue beyond one read and one write.

Test Plan:
- Reset is held 2 cycles, then released → all ready signals are 1 one edge later. A read of addr 0x00 returns 0x00000000, OKAY.
- AW (0x04) and W (0x00000038, strb 4'hF) are presented in the same cycle with bready=1 → bvalid one cycle later with bresp=0. A read of 0x04 returns 0x00000038.
- W alone (0xDEADBEEF, strb 4'b0101), then AW 0x08 three cycles later → wready is low while waiting for the address. Reg2 = 0x00AD00EF. A second write with strb 4'b1010 and data 0x11223344 gives reg2 = 0x11AD33EF.
- bready held low for 5 cycles after a write → bvalid stays high, bresp is stable, and awready/wready stay 0. After bready, the next write is accepted.
- Write to 0x3C (ID register) and to 0x40 → both return bresp=2 (SLVERR). A read of 0x3C returns 0xA5A50001, OKAY. A read of 0x40 returns 0, SLVERR.
- A read of 0x0C and a write of 0x0C=0x12345678 issued at the same edge → rdata returns the old value 0. The next read returns 0x12345678. Asserting reset while rvalid is high (rready=0) clears rvalid at the next edge.
